cla_4bit: RTL and testbench

- Registered 4-bit carry look-ahead adder: sum = in1 + in2 + c_in, with the carry-out.
- All carries come from flat look-ahead equations, not a ripple chain. The result is captured in an output register one clock after the inputs are presented.
- Group propagate/generate outputs let a parent block cascade several instances into wider adders through a second-level look-ahead unit.

---
 rtl/cla_pkg.sv | 8 +
 rtl/cla_4bit_core.sv | 39 +++
 rtl/cla_4bit.sv | 82 ++++++++
 tb/tb_cla_4bit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the 4-bit carry look-ahead adder family.
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    typedef logic [CLA_WIDTH-1:0] cla_nibble_t;

endpackage

// File: rtl/cla_4bit_core.sv
// Combinational 4-bit carry look-ahead slice: flat carry equations plus group P/G
// so a second-level look-ahead unit can cascade several slices.
module cla_4bit_core
    import cla_pkg::*;
(
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       grp_p,
    output logic       grp_g
);

    cla_nibble_t p;
    cla_nibble_t g;
    cla_nibble_t c;
    logic        c4;

    assign p = in1 ^ in2;
    assign g = in1 & in2;

    // Each carry is a two-level sum of products; no carry feeds another.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum   = p ^ c;
    assign c_out = c4;
    assign grp_p = &p;
    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_4bit.sv
// Registered 4-bit carry look-ahead adder: one-cycle latency, result registers
// load only on in_valid, out_valid tracks in_valid every cycle.
module cla_4bit
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out,
    output logic       grp_p,
    output logic       grp_g,
    output logic       out_valid
);

    if (WIDTH != CLA_WIDTH) begin : g_width_chk
        $error("cla_4bit: WIDTH must be 4");
    end

    cla_nibble_t core_sum;
    logic        core_c_out;
    logic        core_grp_p;
    logic        core_grp_g;

    cla_4bit_core u_core (
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .sum   (core_sum),
        .c_out (core_c_out),
        .grp_p (core_grp_p),
        .grp_g (core_grp_g)
    );

    cla_nibble_t sum_q, sum_d;
    logic        c_out_q, c_out_d;
    logic        grp_p_q, grp_p_d;
    logic        grp_g_q, grp_g_d;
    logic        out_valid_q, out_valid_d;

    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        grp_p_d     = grp_p_q;
        grp_g_d     = grp_g_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            sum_d   = core_sum;
            c_out_d = core_c_out;
            grp_p_d = core_grp_p;
            grp_g_d = core_grp_g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            grp_p_q     <= 1'b0;
            grp_g_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            grp_p_q     <= grp_p_d;
            grp_g_q     <= grp_g_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign grp_p     = grp_p_q;
    assign grp_g     = grp_g_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_4bit.sv
// Directed-vector bench for cla_4bit: reset, table of hand-computed sums,
// hold behaviour, mid-stream reset and an exhaustive sweep.
module tb_cla_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;
    logic       grp_p;
    logic       grp_g;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    cla_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .grp_p     (grp_p),
        .grp_g     (grp_g),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [3:0] s;
        logic       co;
        logic       gp;
        logic       gg;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] s, input logic co,
                           input logic gp, input logic gg, input logic ov);
        chk({tag, " sum"},       int'(sum),       int'(s));
        chk({tag, " c_out"},     int'(c_out),     int'(co));
        chk({tag, " grp_p"},     int'(grp_p),     int'(gp));
        chk({tag, " grp_g"},     int'(grp_g),     int'(gg));
        chk({tag, " out_valid"}, int'(out_valid), int'(ov));
    endtask

    vec_t vecs[13];

    initial begin
        int tot;
        logic [3:0] es;
        logic eco, egp, egg;
        vec_t last;

        vecs[0]  = '{4'd4,  4'd4,  1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd4,  4'd12, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[2]  = '{4'd3,  4'd2,  1'b1, 4'd6,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'd5,  4'd0,  1'b1, 4'd6,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd1,  4'd0,  1'b1, 4'd2,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd10, 4'd5,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'd9,  4'd7,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[11] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        vecs[12] = '{4'd7,  4'd1,  1'b1, 4'd9,  1'b0, 1'b0, 1'b0};

        // Reset asserted with arbitrary operands; no clock edge has happened yet.
        rst_n = 1'b0; in_valid = 1'b1; in1 = 4'd9; in2 = 4'd11; c_in = 1'b1;
        #1;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk_all("post-reset idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Table vectors, applied back to back one per cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in1 = vecs[i].a; in2 = vecs[i].b; c_in = vecs[i].ci;
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].gp, vecs[i].gg, 1'b1);
        end
        last = vecs[12];

        // Hold: operands change but in_valid is low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in1 = 4'(i * 5 + 3); in2 = 4'(15 - i); c_in = i[0];
            @(posedge clk); #1;
            chk_all($sformatf("hold%0d", i), last.s, last.co, last.gp, last.gg, 1'b0);
        end

        // Mid-stream reset discards the in-flight result and clears outputs at once.
        @(negedge clk);
        in_valid = 1'b1; in1 = 4'd15; in2 = 4'd15; c_in = 1'b1;
        @(posedge clk); #1;
        chk_all("pre-reset", 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        in1 = 4'd6; in2 = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk_all("after mid reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep against arithmetic sum.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    in_valid = 1'b1; in1 = 4'(a); in2 = 4'(b); c_in = ci[0];
                    tot = a + b + ci;
                    es  = 4'(tot);
                    eco = (tot >= 16);
                    egp = ((a ^ b) == 15);
                    egg = ((a + b) >= 16);
                    @(posedge clk); #1;
                    if ({sum, c_out, grp_p, grp_g, out_valid} !== {es, eco, egp, egg, 1'b1}) begin
                        chk_all($sformatf("sweep %0d+%0d+%0d", a, b, ci), es, eco, egp, egg, 1'b1);
                    end else begin
                        checks++;
                    end
                end
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("final out_valid", int'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
